// File: rtl/ee354_project_snake_body.sv
// Snake body datapath: circular (X,Y) segment buffer on a 16x16 wrap-around grid,
// direction latch, next-head computation, and move/grow on each game tick.
module ee354_project_snake_body #(
   parameter int INIT_LEN = 3,
   parameter int INIT_X   = 4,
   parameter int INIT_Y   = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         SCEN,
   input  logic         q_I,
   input  logic         q_Run,
   input  logic [1:0]   Dir,
   input  logic [3:0]   Food_X,
   input  logic [3:0]   Food_Y,
   output logic [3:0]   Next_Head_X,
   output logic [3:0]   Next_Head_Y,
   output logic [3:0]   Head_X,
   output logic [3:0]   Head_Y,
   output logic [7:0]   Length,
   output logic [255:0] Cell_Snake,
   output logic         Ate
);

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_e;

   // Segment i of the initial body; index 0 is the tail, body extends toward -X.
   function automatic logic [7:0] init_seg(input int i);
      int x;
      x = INIT_X - INIT_LEN + 1 + i;
      return {x[3:0], 4'(INIT_Y)};
   endfunction

   function automatic logic [255:0] init_map();
      logic [255:0] m;
      m = '0;
      for (int i = 0; i < INIT_LEN; i++) m[init_seg(i)] = 1'b1;
      return m;
   endfunction

   localparam logic [255:0] INIT_MAP = init_map();

   logic [7:0]   r_buf [256];
   logic [7:0]   r_head_ptr;
   logic [7:0]   r_tail_ptr;
   logic [7:0]   r_len;
   logic [3:0]   r_head_x;
   logic [3:0]   r_head_y;
   dir_e         r_cur_dir;
   dir_e         r_last_dir;
   logic         r_ate;
   logic [255:0] r_cell;

   logic [3:0]   w_next_x;
   logic [3:0]   w_next_y;
   logic [7:0]   w_next_idx;
   logic [7:0]   w_tail_idx;
   logic         w_move;
   logic         w_eat;
   logic         w_reverse;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_x = r_head_x;
      w_next_y = r_head_y;
      unique case (r_cur_dir)
         DIR_UP:    w_next_y = r_head_y - 4'd1;
         DIR_DOWN:  w_next_y = r_head_y + 4'd1;
         DIR_LEFT:  w_next_x = r_head_x - 4'd1;
         DIR_RIGHT: w_next_x = r_head_x + 4'd1;
      endcase
   end

   // Bit index X*16+Y is simply the concatenated cell coordinate.
   assign w_next_idx = {w_next_x, w_next_y};
   assign w_tail_idx = r_buf[r_tail_ptr];
   assign w_eat      = (w_next_x == Food_X) && (w_next_y == Food_Y);
   assign w_move     = SCEN & q_Run & ~r_cell[w_next_idx] & (r_len != 8'hFF);
   assign w_reverse  = (Dir == (r_last_dir ^ 2'b01));

   // NOTE: the segment buffer is reset because the tail lookup must see valid
   // initial segments immediately after an asynchronous reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 256; i++) r_buf[i] <= (i < INIT_LEN) ? init_seg(i) : 8'h00;
      end else if (q_I) begin
         for (int i = 0; i < 256; i++) r_buf[i] <= (i < INIT_LEN) ? init_seg(i) : 8'h00;
      end else if (w_move) begin
         r_buf[r_head_ptr + 8'd1] <= w_next_idx;
      end
   end

   // NOTE: non-blocking updates; when two bits of r_cell are written in one edge the
   // later statement wins, so the head set is placed after the tail clear.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cell <= INIT_MAP;
      end else if (q_I) begin
         r_cell <= INIT_MAP;
      end else if (w_move) begin
         if (!w_eat) r_cell[w_tail_idx] <= 1'b0;
         r_cell[w_next_idx] <= 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_head_ptr <= 8'(INIT_LEN - 1);
         r_tail_ptr <= 8'd0;
         r_len      <= 8'(INIT_LEN);
         r_head_x   <= 4'(INIT_X);
         r_head_y   <= 4'(INIT_Y);
         r_cur_dir  <= DIR_RIGHT;
         r_last_dir <= DIR_RIGHT;
         r_ate      <= 1'b0;
      end else if (q_I) begin
         r_head_ptr <= 8'(INIT_LEN - 1);
         r_tail_ptr <= 8'd0;
         r_len      <= 8'(INIT_LEN);
         r_head_x   <= 4'(INIT_X);
         r_head_y   <= 4'(INIT_Y);
         r_cur_dir  <= DIR_RIGHT;
         r_last_dir <= DIR_RIGHT;
         r_ate      <= 1'b0;
      end else begin
         // A 180-degree request would fold the head into the neck; keep the old heading.
         if (!w_reverse) r_cur_dir <= dir_e'(Dir);
         r_ate <= w_move & w_eat;
         if (w_move) begin
            r_head_ptr <= r_head_ptr + 8'd1;
            r_head_x   <= w_next_x;
            r_head_y   <= w_next_y;
            r_last_dir <= r_cur_dir;
            if (w_eat) r_len      <= r_len + 8'd1;
            else       r_tail_ptr <= r_tail_ptr + 8'd1;
         end
      end
   end

   assign Next_Head_X = w_next_x;
   assign Next_Head_Y = w_next_y;
   assign Head_X      = r_head_x;
   assign Head_Y      = r_head_y;
   assign Length      = r_len;
   assign Cell_Snake  = r_cell;
   assign Ate         = r_ate;

endmodule

// File: tb/tb_ee354_project_snake_body.sv
// Self-checking bench for ee354_project_snake_body: table of tick vectors through a
// scoreboard queue, plus hand-written init, reversal and reset sequences.
module tb_ee354_project_snake_body;

   logic         Clk = 1'b0;
   logic         Reset, SCEN, q_I, q_Run;
   logic [1:0]   Dir;
   logic [3:0]   Food_X, Food_Y;
   logic [3:0]   Next_Head_X, Next_Head_Y, Head_X, Head_Y;
   logic [7:0]   Length;
   logic [255:0] Cell_Snake;
   logic         Ate;

   ee354_project_snake_body dut (
      .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .q_I(q_I), .q_Run(q_Run), .Dir(Dir),
      .Food_X(Food_X), .Food_Y(Food_Y), .Next_Head_X(Next_Head_X), .Next_Head_Y(Next_Head_Y),
      .Head_X(Head_X), .Head_Y(Head_Y), .Length(Length), .Cell_Snake(Cell_Snake), .Ate(Ate)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int           dir;
      int           fx, fy;
      int           run;
      int           hx, hy, nx, ny;
      int           len;
      int           ate;
      logic [255:0] map;
   } vec_t;

   vec_t tbl[$];
   vec_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_map(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] bitof(input int x, input int y);
      logic [255:0] m;
      m = '0;
      m[8'((x & 15) * 16 + (y & 15))] = 1'b1;
      return m;
   endfunction

   function automatic logic [255:0] row8(input int lo, input int hi);
      logic [255:0] m;
      m = '0;
      for (int x = lo; x <= hi; x++) m |= bitof(x, 8);
      return m;
   endfunction

   function automatic vec_t mk(input int d, input int fx, input int fy, input int run,
                               input int hx, input int hy, input int nx, input int ny,
                               input int len, input int ate, input logic [255:0] map);
      vec_t v;
      v.dir = d;   v.fx = fx;  v.fy = fy;  v.run = run;
      v.hx  = hx;  v.hy = hy;  v.nx = nx;  v.ny  = ny;
      v.len = len; v.ate = ate; v.map = map;
      return v;
   endfunction

   task automatic check_init(input string tag);
      check_map({tag, "_map"}, Cell_Snake, row8(2, 4));
      check({tag, "_pop"},  $countones(Cell_Snake), 3);
      check({tag, "_len"},  int'(Length), 3);
      check({tag, "_hx"},   int'(Head_X), 4);
      check({tag, "_hy"},   int'(Head_Y), 8);
      check({tag, "_nx"},   int'(Next_Head_X), 5);
      check({tag, "_ny"},   int'(Next_Head_Y), 8);
      check({tag, "_ate"},  int'(Ate), 0);
   endtask

   // Direction settles one idle cycle before the tick, since the move uses the latched heading.
   task automatic step(input int idx);
      vec_t  v, e;
      string t;
      v = tbl[idx];
      t = $sformatf("v%0d", idx);
      @(negedge Clk);
      Dir = 2'(v.dir); Food_X = 4'(v.fx); Food_Y = 4'(v.fy); q_Run = v.run[0]; SCEN = 1'b0;
      @(negedge Clk);
      SCEN = 1'b1;
      sb_q.push_back(v);
      @(posedge Clk);
      #1;
      SCEN = 1'b0;
      check({t, "_sb_avail"}, sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({t, "_hx"},  int'(Head_X), e.hx);
         check({t, "_hy"},  int'(Head_Y), e.hy);
         check({t, "_nx"},  int'(Next_Head_X), e.nx);
         check({t, "_ny"},  int'(Next_Head_Y), e.ny);
         check({t, "_len"}, int'(Length), e.len);
         check({t, "_ate"}, int'(Ate), e.ate);
         check({t, "_pop"}, $countones(Cell_Snake), e.len);
         check_map({t, "_map"}, Cell_Snake, e.map);
      end
   endtask

   task automatic pulse_init();
      @(negedge Clk);
      q_Run = 1'b0; SCEN = 1'b0; q_I = 1'b1; Dir = 2'b11;
      @(negedge Clk);
      q_I = 1'b0;
   endtask

   initial begin
      logic [255:0] m;
      int           hx;

      // Scenario 2: twelve right moves with food parked at (0,0), wrapping at X=15.
      for (int k = 1; k <= 12; k++) begin
         hx = (4 + k) % 16;
         m  = bitof(hx, 8) | bitof(hx - 1, 8) | bitof(hx - 2, 8);
         tbl.push_back(mk(3, 0, 0, 1, hx, 8, (hx + 1) % 16, 8, 3, 0, m));
      end
      // 12: tick while not running changes nothing.
      tbl.push_back(mk(3, 0, 0, 0, 4, 8, 5, 8, 3, 0, row8(2, 4)));
      // 13: eat at (5,8).
      tbl.push_back(mk(3, 5, 8, 1, 5, 8, 6, 8, 4, 1, row8(2, 5)));
      // 14..19: grow to 5, turn down, left, then up into own body (twice), then escape left.
      tbl.push_back(mk(3, 6, 8, 1, 6, 8, 7, 8, 5, 1, row8(2, 6)));
      tbl.push_back(mk(1, 0, 0, 1, 6, 9, 6, 10, 5, 0, row8(3, 6) | bitof(6, 9)));
      m = row8(4, 6) | bitof(6, 9) | bitof(5, 9);
      tbl.push_back(mk(2, 0, 0, 1, 5, 9, 4, 9, 5, 0, m));
      tbl.push_back(mk(0, 0, 0, 1, 5, 9, 5, 8, 5, 0, m));
      tbl.push_back(mk(0, 0, 0, 1, 5, 9, 5, 8, 5, 0, m));
      tbl.push_back(mk(2, 0, 0, 1, 4, 9, 3, 9, 5, 0,
                       row8(5, 6) | bitof(6, 9) | bitof(5, 9) | bitof(4, 9)));
      // 20..22: length-4 loop whose next head is the current tail cell.
      tbl.push_back(mk(1, 4, 9, 1, 4, 9, 4, 10, 4, 1, row8(2, 4) | bitof(4, 9)));
      m = row8(3, 4) | bitof(4, 9) | bitof(3, 9);
      tbl.push_back(mk(2, 0, 0, 1, 3, 9, 2, 9, 4, 0, m));
      tbl.push_back(mk(0, 0, 0, 1, 3, 9, 3, 8, 4, 0, m));

      Reset = 1'b0; SCEN = 1'b0; q_I = 1'b0; q_Run = 1'b0;
      Dir = 2'b11; Food_X = 4'd0; Food_Y = 4'd0;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check_init("s1");

      for (int i = 0; i <= 11; i++) step(i);

      pulse_init();
      check_init("s6_qi");

      for (int i = 12; i <= 13; i++) step(i);
      @(posedge Clk);
      #1;
      check("s3_ate_clear", int'(Ate), 0);
      check("s3_len_hold", int'(Length), 4);

      // Scenario 4: reversal to the left is ignored, a turn up is accepted.
      @(negedge Clk);
      Dir = 2'b10;
      @(negedge Clk);
      check("s4_rev_nx", int'(Next_Head_X), 6);
      check("s4_rev_ny", int'(Next_Head_Y), 8);
      Dir = 2'b00;
      @(negedge Clk);
      check("s4_up_nx", int'(Next_Head_X), 5);
      check("s4_up_ny", int'(Next_Head_Y), 7);

      for (int i = 14; i <= 19; i++) step(i);

      pulse_init();
      check_init("s6_qi2");
      for (int i = 20; i <= 22; i++) step(i);

      // Scenario 6: reset asserted mid-cycle while a legal move is being ticked.
      @(negedge Clk);
      Dir = 2'b01; q_Run = 1'b1; Food_X = 4'd0; Food_Y = 4'd0;
      @(negedge Clk);
      check("s6_pre_nx", int'(Next_Head_X), 3);
      check("s6_pre_ny", int'(Next_Head_Y), 10);
      SCEN = 1'b1;
      #2;
      Reset = 1'b0;
      Dir = 2'b11;
      @(posedge Clk);
      #1;
      SCEN = 1'b0;
      check_init("s6_hold");
      @(negedge Clk);
      Reset = 1'b1;
      q_Run = 1'b0;
      @(negedge Clk);
      check_init("s6_rst");

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
